// File: rtl/dispatch_unit.sv
// dispatch_unit: takes one fetch bundle at a time and walks its slots in
// order. Each slot is classified and then either sent to the ALU, load or
// store channel, resolved as a conditional branch through an operand query,
// flagged as illegal, or skipped if it is an all-zero word. A rename table
// records which architectural registers are waiting on an in-flight result
// and which tag will produce it.
//
// Handshake rule for every channel (fb_*, alu_*, ld_*, st_*, br_*):
// a transfer happens on a rising edge where valid (or req) and ready
// (or ack) are both high. While valid is high and ready is low, the
// payload stays unchanged. The producer never waits for ready before
// raising valid.
module dispatch_unit #(
    parameter int FETCH_W = 8,
    parameter int TAG_W   = 6,
    parameter int NREG    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // fetch bundle in, next fetch address out
    input  logic                  fb_valid,
    output logic                  fb_ready,
    input  logic [32*FETCH_W-1:0] fb_instr,
    input  logic [31:0]           fb_pc,
    output logic [31:0]           fetch_pc,
    output logic                  redir_valid,
    // ALU channel
    output logic                  alu_valid,
    input  logic                  alu_ready,
    output logic [31:0]           alu_instr,
    output logic [TAG_W-1:0]      alu_tag,
    output logic [31:0]           alu_pc,
    // load channel
    output logic                  ld_valid,
    input  logic                  ld_ready,
    output logic [31:0]           ld_instr,
    output logic [TAG_W-1:0]      ld_tag,
    output logic [31:0]           ld_pc,
    // store channel
    output logic                  st_valid,
    input  logic                  st_ready,
    output logic [31:0]           st_instr,
    output logic [TAG_W-1:0]      st_tag,
    output logic [31:0]           st_pc,
    // rename lookup for the presented slot
    output logic                  src1_busy,
    output logic                  src2_busy,
    output logic [TAG_W-1:0]      src1_tag,
    output logic [TAG_W-1:0]      src2_tag,
    // branch operand query
    output logic                  br_req,
    output logic [4:0]            br_rs,
    output logic [4:0]            br_rt,
    input  logic                  br_ack,
    input  logic [31:0]           br_val1,
    input  logic [31:0]           br_val2,
    // commit notification
    input  logic                  cmt_valid,
    input  logic [4:0]            cmt_ar,
    input  logic [TAG_W-1:0]      cmt_tag,
    output logic                  illegal,
    // FSM state for observation
    output logic [1:0]            dbg_state
);

    localparam int IDX_W = $clog2(FETCH_W);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DISP    = 2'd1,
        S_BR_WAIT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        bpc_q;
    logic [31:0]        slot_q [FETCH_W];
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [TAG_W-1:0]   tag_cnt_q, tag_cnt_d;
    logic               redir_q, redir_d;
    logic               illegal_q, illegal_d;
    logic [NREG-1:0]    busy_q;
    logic [TAG_W-1:0]   rtag_q [NREG];

    logic               latch_bundle;
    logic               advance;
    logic               fire;

    // decode of the slot currently being handled
    logic [31:0]        cur_instr;
    logic [5:0]         opcode;
    logic [31:0]        slot_pc;
    logic               is_nop, is_alu, is_ld, is_st, is_beq, is_bne;
    logic               has_dest;
    logic [4:0]         dest_reg;
    logic [4:0]         src1_reg, src2_reg;
    logic               br_taken;
    logic [31:0]        br_target;
    logic               last_slot;
    logic               unit_ready;

    // classify the presented slot and derive its PC and branch target
    always_comb begin
        cur_instr = slot_q[idx_q];
        opcode    = cur_instr[31:26];
        slot_pc   = bpc_q + {{(30-IDX_W){1'b0}}, idx_q, 2'b00};
        is_nop    = (cur_instr == 32'd0);
        is_alu    = !is_nop && (opcode inside {6'b000000, 6'b001000, 6'b001001,
                                               6'b000110, 6'b001011, 6'b001100,
                                               6'b001101, 6'b001110, 6'b001111});
        is_ld     = (opcode == 6'b100011);
        is_st     = (opcode == 6'b101011);
        is_beq    = (opcode == 6'b000100);
        is_bne    = (opcode == 6'b000101);
        has_dest  = is_alu || is_ld;
        dest_reg  = (opcode == 6'b000000) ? cur_instr[15:11] : cur_instr[20:16];
        src1_reg  = cur_instr[25:21];
        src2_reg  = cur_instr[20:16];
        br_taken  = is_beq ? (br_val1 == br_val2) : (br_val1 != br_val2);
        br_target = slot_pc + 32'd4 + {{14{cur_instr[15]}}, cur_instr[15:0], 2'b00};
        last_slot = (idx_q == IDX_W'(FETCH_W - 1));
        unit_ready = is_alu ? alu_ready : (is_ld ? ld_ready : st_ready);
    end

    // next-state logic and channel outputs
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fetch_pc_d   = fetch_pc_q;
        tag_cnt_d    = tag_cnt_q;
        redir_d      = 1'b0;
        illegal_d    = 1'b0;
        latch_bundle = 1'b0;
        advance      = 1'b0;
        fire         = 1'b0;
        fb_ready     = 1'b0;
        alu_valid    = 1'b0;
        alu_instr    = '0;
        alu_tag      = '0;
        alu_pc       = '0;
        ld_valid     = 1'b0;
        ld_instr     = '0;
        ld_tag       = '0;
        ld_pc        = '0;
        st_valid     = 1'b0;
        st_instr     = '0;
        st_tag       = '0;
        st_pc        = '0;
        br_req       = 1'b0;
        br_rs        = '0;
        br_rt        = '0;

        case (state_q)
            S_IDLE: begin
                // the reset cycle itself must not accept a bundle
                fb_ready = rst;
                if (fb_valid) begin
                    latch_bundle = 1'b1;
                    idx_d        = '0;
                    state_d      = S_DISP;
                end
            end
            S_DISP: begin
                if (is_nop) begin
                    advance = 1'b1;
                end else if (is_alu || is_ld || is_st) begin
                    if (is_alu) begin
                        alu_valid = 1'b1;
                        alu_instr = cur_instr;
                        alu_tag   = tag_cnt_q;
                        alu_pc    = slot_pc;
                    end else if (is_ld) begin
                        ld_valid  = 1'b1;
                        ld_instr  = cur_instr;
                        ld_tag    = tag_cnt_q;
                        ld_pc     = slot_pc;
                    end else begin
                        st_valid  = 1'b1;
                        st_instr  = cur_instr;
                        st_tag    = tag_cnt_q;
                        st_pc     = slot_pc;
                    end
                    if (unit_ready) begin
                        fire      = 1'b1;
                        tag_cnt_d = tag_cnt_q + TAG_W'(1);
                        advance   = 1'b1;
                    end
                end else if (is_beq || is_bne) begin
                    state_d = S_BR_WAIT;
                end else begin
                    illegal_d = 1'b1;
                    advance   = 1'b1;
                end
            end
            S_BR_WAIT: begin
                br_req = 1'b1;
                br_rs  = cur_instr[25:21];
                br_rt  = cur_instr[20:16];
                if (br_ack) begin
                    if (br_taken) begin
                        redir_d    = 1'b1;
                        fetch_pc_d = br_target;
                        state_d    = S_IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // leaving a slot: either step to the next one or close the bundle
        if (advance) begin
            if (last_slot) begin
                fetch_pc_d = bpc_q + 32'(4 * FETCH_W);
                state_d    = S_IDLE;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = S_DISP;
            end
        end
    end

    // FSM, bundle storage, tag counter and pulse registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            bpc_q      <= '0;
            fetch_pc_q <= '0;
            tag_cnt_q  <= '0;
            redir_q    <= 1'b0;
            illegal_q  <= 1'b0;
            for (int i = 0; i < FETCH_W; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            fetch_pc_q <= fetch_pc_d;
            tag_cnt_q  <= tag_cnt_d;
            redir_q    <= redir_d;
            illegal_q  <= illegal_d;
            if (latch_bundle) begin
                bpc_q <= fb_pc;
                for (int i = 0; i < FETCH_W; i++) begin
                    slot_q[i] <= fb_instr[32*i +: 32];
                end
            end
        end
    end

    // rename table: commit clears only for the newest writer; a dispatch in
    // the same cycle is applied last so it overrides the clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                rtag_q[i] <= '0;
            end
        end else begin
            if (cmt_valid && (rtag_q[cmt_ar] == cmt_tag)) begin
                busy_q[cmt_ar] <= 1'b0;
            end
            if (fire && has_dest && (dest_reg != 5'd0)) begin
                busy_q[dest_reg] <= 1'b1;
                rtag_q[dest_reg] <= tag_cnt_q;
            end
        end
    end

    // source lookup for the presented slot; register 0 is never busy
    always_comb begin
        src1_busy = 1'b0;
        src2_busy = 1'b0;
        src1_tag  = '0;
        src2_tag  = '0;
        if (state_q == S_DISP) begin
            if (src1_reg != 5'd0) begin
                src1_busy = busy_q[src1_reg];
                src1_tag  = rtag_q[src1_reg];
            end
            if (src2_reg != 5'd0) begin
                src2_busy = busy_q[src2_reg];
                src2_tag  = rtag_q[src2_reg];
            end
        end
    end

    assign fetch_pc    = fetch_pc_q;
    assign redir_valid = redir_q;
    assign illegal     = illegal_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/dispatch_unit.md
DISPATCH_UNIT -- requirements
Module: dispatch_unit

Interface
REQ-001 SHALL have parameter FETCH_W, default 8, meaning instructions per fetch bundle (power of two, 2..16).
REQ-002 SHALL have parameter TAG_W, default 6, meaning instruction-number tag width.
REQ-003 SHALL have parameter NREG, default 32, meaning architectural register count.
REQ-004 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-low reset.
REQ-005 SHALL have ports: fb_valid in 1 bundle valid; fb_ready out 1 bundle accepted; fb_instr in 32*FETCH_W (slot i at [32i+31:32i]); fb_pc in 32 PC of slot 0.
REQ-006 SHALL have ports: fetch_pc out 32 next bundle PC; redir_valid out 1 one-cycle redirect pulse.
REQ-007 SHALL have, per unit U in {alu, ld, st}: U_valid out 1; U_ready in 1; U_instr out 32; U_tag out TAG_W; U_pc out 32.
REQ-008 SHALL have ports: src1_busy, src2_busy out 1; src1_tag, src2_tag out TAG_W (rename lookup for the presented instruction).
REQ-009 SHALL have ports: br_req out 1; br_rs, br_rt out 5; br_ack in 1; br_val1, br_val2 in 32 (branch operand query to ROB/regfile).
REQ-010 SHALL have ports: cmt_valid in 1; cmt_ar in 5; cmt_tag in TAG_W (commit notification); illegal out 1 (one-cycle pulse).

Function
REQ-011 SHALL implement FSM states IDLE, DISP, BR_WAIT.
REQ-012 IDLE: fb_ready=1; on fb_valid latch bundle and fb_pc, slot index=0, go DISP; fb_ready=0 in all other states.
REQ-013 DISP handles one slot per cycle minimum; slot PC = bundle_pc + 4*index.
REQ-014 Slot word 0 SHALL be skipped in one cycle, no tag consumed.
REQ-015 ALU class: opcode 000000,001000,001001,000110,001011,001100,001101,001110,001111 -> alu channel; lw 100011 -> ld; sw 101011 -> st.
REQ-016 Exactly one U_valid high at a time; instr/tag/pc/src fields stable while U_valid and !U_ready; slot advances on the cycle U_valid&&U_ready.
REQ-017 Tag counter increments by 1 per accepted dispatch, modulo 2^TAG_W; tags never consumed by skips, branches or illegals.
REQ-018 Rename table: busy[NREG], tag[NREG]; dest = [15:11] for opcode 0, [20:16] for other ALU and lw; sw has no dest; dest 0 never marked busy.
REQ-019 On accepted dispatch with dest: busy[dest]=1, tag[dest]=dispatched tag.
REQ-020 On cmt_valid: clear busy[cmt_ar] only if tag[cmt_ar]==cmt_tag; simultaneous dispatch to same register wins.
REQ-021 src1 = [25:21], src2 = [20:16]; busy/tag outputs combinational from table for the presented slot; register 0 always not busy.
REQ-022 Opcode 000100 (beq) / 000101 (bne): go BR_WAIT, br_req=1, br_rs=[25:21], br_rt=[20:16], held until br_ack.
REQ-023 On br_ack: taken = (val1==val2) for beq, (val1!=val2) for bne.
REQ-024 Taken: target = slot_pc + 4 + (sign-extended [15:0] << 2), 32-bit wrap; redir_valid pulse; fetch_pc=target; remaining slots dropped; go IDLE.
REQ-025 Not taken: resume DISP at next slot (or IDLE if last slot).
REQ-026 Any other opcode: illegal pulse one cycle, slot skipped.
REQ-027 After last slot completes without redirect: fetch_pc = bundle_pc + 4*FETCH_W, go IDLE.
REQ-028 Back-to-back bundles: IDLE lasts at least one cycle between bundles.

Reset
REQ-029 rst=0 at a clock edge: state IDLE, fetch_pc=0, tag counter 0, all busy=0, all valid/req/pulse outputs 0, fb_ready=0 that cycle; any in-flight bundle or branch query is discarded.
REQ-030 Data outputs (U_instr, U_tag, U_pc, br_rs, br_rt) SHALL reset to 0.

Verification
REQ-031 Bundle of 8 ALU ops, all readies high, fb_pc=0x100 -> tags 0..7 over 8 DISP cycles, fetch_pc=0x120.
REQ-032 lw r3 dispatched with ld_ready low 3 cycles -> ld_valid held 4 cycles, fields stable, tag used once; next add r4,r3,r3 sees src1_busy=1, src1_tag=lw tag.
REQ-033 beq at slot 2, PC 0x208, imm 0xFFFE, br_val1==br_val2 -> redir_valid pulse, fetch_pc=0x204, slots 3..7 never dispatched.
REQ-034 bne with equal values -> no redirect, slot 3 dispatched next.
REQ-035 Commit r5 with stale tag while newer writer pending -> busy[5] stays 1; matching tag -> cleared; commit same cycle as new dispatch to r5 -> busy stays 1, new tag.
REQ-036 rst=0 asserted while alu_valid held and BR_WAIT pending -> next cycle all valids 0, fetch_pc=0, tag counter 0.
